// File: rtl/packet_load_ctrl.sv
// Packet loader: turns 3-byte UART packets into pixel RAM writes, then releases
// the CPU for one inference run each time a full frame has been accepted.
module packet_load_ctrl #(
    parameter int          NUM_PIXELS = 784,
    parameter logic [13:0] BASE_ADDR  = 14'h0000,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [13:0] ram_addr,
    output logic [23:0] ram_data_in,
    output logic        ram_we,
    output logic        cpu_rst,
    input  logic        cpu_halt,
    output logic        frame_done,
    output logic [31:0] count_packets,
    output logic [15:0] err_count,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_B0    = 3'd0,
        S_B1    = 3'd1,
        S_B2    = 3'd2,
        S_CHECK = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FW = $clog2(NUM_PIXELS + 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FRAME_FULL = FW'(NUM_PIXELS);

    state_t        r_state;
    logic [7:0]    r_byte0;
    logic [7:0]    r_byte1;
    logic [GW-1:0] r_gap;
    logic [FW-1:0] r_frame_cnt;
    logic [13:0]   r_ram_addr;
    logic [23:0]   r_ram_data;
    logic          r_ram_we;
    logic          r_cpu_rst;
    logic          r_frame_done;
    logic [31:0]   r_count;
    logic [15:0]   r_err_count;

    logic [23:0] w_pkt;
    logic [2:0]  w_hdr;
    logic [9:0]  w_loc;
    logic [7:0]  w_data;
    logic [2:0]  w_ftr;
    logic        w_accept;
    logic        w_timeout;
    logic [15:0] w_err_next;

    // Packet is judged on the byte2 strobe so the write lands in the CHECK cycle.
    assign w_pkt  = {r_byte0, r_byte1, rx_data};
    assign w_hdr  = w_pkt[23:21];
    assign w_loc  = w_pkt[20:11];
    assign w_data = w_pkt[10:3];
    assign w_ftr  = w_pkt[2:0];

    assign w_accept = (w_hdr == 3'b101)
                   && (w_ftr[2] == ^w_data)
                   && (w_ftr[1] == ^w_loc)
                   && (w_ftr[0] == ^{w_data[7:4], w_loc[9:5]})
                   && (32'(w_loc) < 32'(NUM_PIXELS));

    assign w_timeout  = !rx_valid && (r_gap == GAP_LAST);
    assign w_err_next = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

    // Gap counter only runs while a packet is partially received.
    always_ff @(posedge clk) begin
        if (rst || rx_valid || w_timeout || !(r_state == S_B1 || r_state == S_B2))
            r_gap <= '0;
        else
            r_gap <= r_gap + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_B0;
            r_byte0      <= 8'h00;
            r_byte1      <= 8'h00;
            r_frame_cnt  <= '0;
            r_ram_addr   <= 14'h0000;
            r_ram_data   <= 24'h000000;
            r_ram_we     <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_frame_done <= 1'b0;
            r_count      <= 32'd0;
            r_err_count  <= 16'd0;
        end else begin
            r_ram_we     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_B0: begin
                    if (rx_valid) begin
                        r_byte0 <= rx_data;
                        r_state <= S_B1;
                    end
                end
                S_B1: begin
                    if (rx_valid) begin
                        r_byte1 <= rx_data;
                        r_state <= S_B2;
                    end else if (w_timeout) begin
                        r_state <= S_B0;
                    end
                end
                S_B2: begin
                    if (rx_valid) begin
                        r_state <= S_CHECK;
                        if (w_accept) begin
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= BASE_ADDR + {4'b0000, w_loc};
                            r_ram_data  <= {16'h0000, w_data};
                            r_count     <= r_count + 32'd1;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_err_count <= w_err_next;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_B0;
                    end
                end
                S_CHECK: begin
                    if (r_frame_cnt == FRAME_FULL) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                    end else if (rx_valid) begin
                        r_byte0 <= rx_data;
                        r_state <= S_B1;
                    end else begin
                        r_state <= S_B0;
                    end
                end
                S_RUN: begin
                    if (rx_valid)
                        r_err_count <= w_err_next;
                    if (cpu_halt) begin
                        r_state      <= S_DONE;
                        r_cpu_rst    <= 1'b1;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (rx_valid)
                        r_err_count <= w_err_next;
                    r_frame_cnt <= '0;
                    r_state     <= S_B0;
                end
                default: r_state <= S_B0;
            endcase
        end
    end

    assign ram_addr      = r_ram_addr;
    assign ram_data_in   = r_ram_data;
    assign ram_we        = r_ram_we;
    assign cpu_rst       = r_cpu_rst;
    assign frame_done    = r_frame_done;
    assign count_packets = r_count;
    assign err_count     = r_err_count;
    assign state_o       = r_state;

endmodule

// File: tb/tb_packet_load_ctrl.sv
// Bench for packet_load_ctrl: fixed vector table, hand-written corner sequences,
// then random packets checked against an arithmetic packet model.
module tb_packet_load_ctrl;

    localparam int          NUM_PIXELS = 20;
    localparam logic [13:0] BASE       = 14'h3FF8;
    localparam int          TIMEOUT    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [13:0] ram_addr;
    logic [23:0] ram_data_in;
    logic        ram_we;
    logic        cpu_rst;
    logic        cpu_halt;
    logic        frame_done;
    logic [31:0] count_packets;
    logic [15:0] err_count;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    packet_load_ctrl #(
        .NUM_PIXELS(NUM_PIXELS),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_we       (ram_we),
        .cpu_rst      (cpu_rst),
        .cpu_halt     (cpu_halt),
        .frame_done   (frame_done),
        .count_packets(count_packets),
        .err_count    (err_count),
        .state_o      (state_o)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic        we;
        logic [13:0] addr;
        logic [23:0] data;
    } vec_t;

    vec_t        tbl[7];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [37:0] exp_q[$];
    logic [37:0] mon_e;
    logic [31:0] exp_count;
    logic [15:0] exp_err;
    int          exp_frame;
    int          frames_done;
    logic [13:0] last_addr;
    logic [23:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && ram_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ram_addr, ram_data_in);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ram_addr, ram_data_in} !== mon_e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_addr, ram_data_in, mon_e[37:24], mon_e[23:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_count = 0;
        exp_err   = 0;
        exp_frame = 0;
        last_addr = 0;
        last_data = 0;
    endtask

    task automatic note_pkt(input logic acc, input logic [13:0] addr, input logic [23:0] data);
        if (acc) begin
            exp_q.push_back({addr, data});
            exp_count++;
            exp_frame++;
            last_addr = addr;
            last_data = data;
        end else if (exp_err != 16'hFFFF) begin
            exp_err++;
        end
    endtask

    // Reference model: field extraction and checks by plain arithmetic on the 24-bit value.
    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output logic acc, output logic [13:0] addr, output logic [23:0] data);
        int unsigned p, hdr, loc, dat, ftr;
        p   = b0 * 65536 + b1 * 256 + b2;
        hdr = p / 2097152;
        loc = (p / 2048) % 1024;
        dat = (p / 8) % 256;
        ftr = p % 8;
        acc = (hdr == 5)
           && ((ftr / 4) == $countones(dat) % 2)
           && (((ftr / 2) % 2) == $countones(loc) % 2)
           && ((ftr % 2) == ($countones(dat / 16) + $countones(loc / 32)) % 2)
           && (loc < NUM_PIXELS);
        addr = 14'((int'(BASE) + loc) % 16384);
        data = 24'(dat);
    endtask

    function automatic logic [23:0] build(input int unsigned loc, input int unsigned dat);
        int unsigned ftr;
        ftr = 4 * ($countones(dat) % 2) + 2 * ($countones(loc) % 2)
            + (($countones(dat / 16) + $countones(loc / 32)) % 2);
        return 24'(5 * 2097152 + loc * 2048 + dat * 8 + ftr);
    endfunction

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic acc, input logic [13:0] addr, input logic [23:0] data,
                            input int gap);
        idle(gap);
        drive(b0);
        idle(gap);
        drive(b1);
        idle(gap);
        note_pkt(acc, addr, data);
        drive(b2);
        chk("check_state", state_o, 3);
        chk("ram_we_in_check", ram_we, acc);
        chk("cpu_rst_in_check", cpu_rst, 1);
        @(negedge clk);
        if (exp_frame == NUM_PIXELS) begin
            chk("enter_run_state", state_o, 4);
            chk("cpu_rst_run", cpu_rst, 0);
        end else begin
            chk("back_to_b0", state_o, 0);
            chk("cpu_rst_b0", cpu_rst, 1);
        end
        chk("ram_we_after_check", ram_we, 0);
        chk("count_packets", count_packets, exp_count);
        chk("err_count", err_count, exp_err);
        chk("addr_hold", ram_addr, last_addr);
        chk("data_hold", ram_data_in, last_data);
    endtask

    task automatic run_frame();
        drive(8'h55);
        if (exp_err != 16'hFFFF)
            exp_err++;
        chk("run_byte_state", state_o, 4);
        chk("run_byte_err", err_count, exp_err);
        idle(2);
        chk("run_wait_state", state_o, 4);
        chk("run_no_done", frame_done, 0);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        chk("done_state", state_o, 5);
        chk("frame_done_pulse", frame_done, 1);
        chk("done_cpu_rst", cpu_rst, 1);
        @(negedge clk);
        chk("after_done_state", state_o, 0);
        chk("frame_done_low", frame_done, 0);
        chk("count_kept", count_packets, exp_count);
        exp_frame = 0;
        frames_done++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pkt;
        logic        acc;
        logic [13:0] addr;
        logic [23:0] data;
        int          gap;

        tbl[0] = '{8'hA0, 8'h00, 8'h00, 1'b1, 14'h3FF8, 24'h000000};
        tbl[1] = '{8'hA0, 8'h1A, 8'hD0, 1'b1, 14'h3FFB, 24'h00005A};
        tbl[2] = '{8'hA0, 8'h1A, 8'hD1, 1'b0, 14'h0000, 24'h000000};
        tbl[3] = '{8'h80, 8'h00, 8'h00, 1'b0, 14'h0000, 24'h000000};
        tbl[4] = '{8'hA0, 8'hA0, 8'h00, 1'b0, 14'h0000, 24'h000000};
        tbl[5] = '{8'hA0, 8'h98, 8'h02, 1'b1, 14'h000B, 24'h000000};
        tbl[6] = '{8'hA0, 8'h3F, 8'hFA, 1'b1, 14'h3FFF, 24'h0000FF};

        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        cpu_halt    = 1'b0;
        frames_done = 0;
        clear_model();
        idle(3);
        rst = 1'b0;

        chk("rst_state", state_o, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data_in, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_count", count_packets, 0);
        chk("rst_err", err_count, 0);

        for (int i = 0; i < 7; i++)
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].we, tbl[i].addr, tbl[i].data, 1);

        // A byte arriving during CHECK becomes byte0 of the next packet.
        note_pkt(1'b1, 14'h3FF8, 24'h000000);
        rx_data = 8'hA0; rx_valid = 1'b1; @(negedge clk);
        rx_data = 8'h00; @(negedge clk);
        rx_data = 8'h00; @(negedge clk);
        chk("b2b_check1_state", state_o, 3);
        chk("b2b_check1_we", ram_we, 1);
        note_pkt(1'b1, 14'h3FFB, 24'h00005A);
        rx_data = 8'hA0; @(negedge clk);
        chk("b2b_b1_state", state_o, 1);
        rx_data = 8'h1A; @(negedge clk);
        chk("b2b_b2_state", state_o, 2);
        rx_data = 8'hD0; @(negedge clk);
        rx_valid = 1'b0;
        chk("b2b_check2_state", state_o, 3);
        chk("b2b_check2_we", ram_we, 1);
        @(negedge clk);
        chk("b2b_end_state", state_o, 0);
        chk("b2b_count", count_packets, exp_count);

        // Partial packet abandoned by timeout; cpu_halt must be ignored meanwhile.
        cpu_halt = 1'b1;
        drive(8'hA0);
        idle(TIMEOUT + 5);
        chk("timeout_state", state_o, 0);
        chk("halt_ignored", frame_done, 0);
        cpu_halt = 1'b0;
        send_pkt(8'hA0, 8'h1A, 8'hD0, 1'b1, 14'h3FFB, 24'h00005A, 1);

        // Reset between byte1 and byte2.
        drive(8'hA0);
        drive(8'h1A);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        chk("midrst_state", state_o, 0);
        chk("midrst_we", ram_we, 0);
        chk("midrst_count", count_packets, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_addr", ram_addr, 0);
        send_pkt(8'hA0, 8'h1A, 8'hD0, 1'b1, 14'h3FFB, 24'h00005A, 0);

        for (int i = 0; i < 200 && frames_done < 2; i++) begin
            pkt = build($urandom_range(0, NUM_PIXELS + 3), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                pkt = pkt ^ (24'd1 << $urandom_range(0, 23));
            gap = ($urandom_range(0, 9) == 0) ? TIMEOUT - 2 : int'($urandom_range(0, 3));
            model_pkt(pkt[23:16], pkt[15:8], pkt[7:0], acc, addr, data);
            send_pkt(pkt[23:16], pkt[15:8], pkt[7:0], acc, addr, data, gap);
            if (exp_frame == NUM_PIXELS)
                run_frame();
        end
        chk("frames_completed", frames_done, 2);

        idle(2);
        chk("writes_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
